// File: rtl/bcd_seg_scan_driver_if.sv
// bcd_seg_scan_driver_if: BCD word in, multiplexed seven-segment pins out
interface bcd_seg_scan_driver_if #(
  parameter int DIGITS = 2
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic                enable;
  logic [6:0]          seg_out;
  logic [DIGITS-1:0]   an_out;
  logic                digit_err;
  logic                frame_done;
  modport master (output bcd_in, load, enable, input seg_out, an_out, digit_err, frame_done);
  modport slave  (input bcd_in, load, enable, output seg_out, an_out, digit_err, frame_done);
endinterface

// File: rtl/bcd_seg_scan_driver.sv
// bcd_seg_scan_driver: latches a packed BCD word and scans it onto a multiplexed seven-segment display
module bcd_seg_scan_driver #(
  parameter int DIGITS         = 2,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  bcd_seg_scan_driver_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
  // gfedcba active-high; A-F show a dash
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [4*DIGITS-1:0] shadow_q;
  logic                err_q, err_d, fd_q, fd_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d, lit;
  logic [DIGITS-1:0]   an_q, an_d, sel;
  logic [3:0]          nib;
  logic                blank, zero, last, on;
  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) err_d = err_d | (bus.bcd_in[4*i +: 4] > 4'd9);
  end
  always_comb begin
    nib = 4'd0;
    blank = 1'b0;
    zero = 1'b1;
    // walk from the most significant digit so zero means "this and all above are 0"
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero = zero & (shadow_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        nib = shadow_q[4*i +: 4];
        blank = BLANK_LZ && (i > 0) && zero;
      end
    end
    lit = DEC[nib];
    sel = DIGITS'(1) << idx_q;
    last = pre_q == PW'(PRESCALE - 1);
    pre_d = bus.enable ? (last ? '0 : pre_q + PW'(1)) : pre_q;
    idx_d = (bus.enable && last) ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    fd_d = bus.enable && last && idx_q == IW'(DIGITS - 1);
    on = bus.enable && pre_q != '0;
    seg_d = (on && !blank) ? (SEG_ACTIVE_LOW ? ~lit : lit) : SEG_OFF;
    an_d = on ? (AN_ACTIVE_LOW ? ~sel : sel) : AN_OFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      err_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      an_q <= AN_OFF;
      fd_q <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_q <= bus.bcd_in;
        err_q <= err_d;
      end
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
      fd_q <= fd_d;
    end
  end
  assign bus.seg_out = seg_q;
  assign bus.an_out = an_q;
  assign bus.digit_err = err_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// tb_bcd_seg_scan_driver: directed vectors for the 2-digit scan driver with PRESCALE=4
module tb_bcd_seg_scan_driver;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  bcd_seg_scan_driver_if #(.DIGITS(2)) bus ();
  bcd_seg_scan_driver #(.DIGITS(2), .PRESCALE(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [1:0] ea, input logic [6:0] es, input logic ef, input logic ee);
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    check({tag, ".an"}, 32'(bus.an_out), 32'(ea));
    check({tag, ".seg"}, 32'(bus.seg_out), 32'(es));
    check({tag, ".fd"}, 32'(bus.frame_done), 32'(ef));
    check({tag, ".err"}, 32'(bus.digit_err), 32'(ee));
  endtask
  task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1, input logic ee);
    cyc({tag, ".g0"}, 2'b11, 7'h7F, 1'b0, ee);
    repeat (3) cyc({tag, ".d0"}, 2'b10, s0, 1'b0, ee);
    cyc({tag, ".g1"}, 2'b11, 7'h7F, 1'b0, ee);
    repeat (2) cyc({tag, ".d1"}, 2'b01, s1, 1'b0, ee);
    cyc({tag, ".d1w"}, 2'b01, s1, 1'b1, ee);
  endtask
  task automatic ld(input logic [7:0] v);
    bus.bcd_in = v;
    bus.load = 1'b1;
  endtask
  initial begin
    reset = 1'b1;
    bus.bcd_in = 8'h00;
    bus.load = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.an", 32'(bus.an_out), 32'h3);
    check("rst.seg", 32'(bus.seg_out), 32'h7F);
    check("rst.err", 32'(bus.digit_err), 32'h0);
    check("rst.fd", 32'(bus.frame_done), 32'h0);
    reset = 1'b0;
    bus.enable = 1'b1;
    ld(8'h47);
    frame("scan47a", ~7'h07, ~7'h66, 1'b0);
    frame("scan47b", ~7'h07, ~7'h66, 1'b0);
    ld(8'h05);
    frame("lz05", ~7'h6D, 7'h7F, 1'b0);
    ld(8'h00);
    frame("lz00", ~7'h3F, 7'h7F, 1'b0);
    ld(8'h3C);
    frame("bad3C", ~7'h40, ~7'h4F, 1'b1);
    ld(8'h12);
    frame("ok12", ~7'h5B, ~7'h06, 1'b0);
    cyc("hold.g0", 2'b11, 7'h7F, 1'b0, 1'b0);
    cyc("hold.d0", 2'b10, ~7'h5B, 1'b0, 1'b0);
    bus.enable = 1'b0;
    repeat (10) cyc("hold.off", 2'b11, 7'h7F, 1'b0, 1'b0);
    bus.enable = 1'b1;
    cyc("resume.p2", 2'b10, ~7'h5B, 1'b0, 1'b0);
    cyc("resume.p3", 2'b10, ~7'h5B, 1'b0, 1'b0);
    cyc("resume.g1", 2'b11, 7'h7F, 1'b0, 1'b0);
    repeat (2) cyc("resume.d1", 2'b01, ~7'h06, 1'b0, 1'b0);
    cyc("resume.d1w", 2'b01, ~7'h06, 1'b1, 1'b0);
    cyc("mid.g0", 2'b11, 7'h7F, 1'b0, 1'b0);
    cyc("mid.d0", 2'b10, ~7'h5B, 1'b0, 1'b0);
    reset = 1'b1;
    ld(8'h99);
    cyc("mid.rst", 2'b11, 7'h7F, 1'b0, 1'b0);
    reset = 1'b0;
    frame("post_rst", ~7'h3F, 7'h7F, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scan_driver.md
Name: bcd_seg_scan_driver

Overview:
- Downstream consumer of the 2-digit BCD counter output: latches a packed BCD word and drives a time-multiplexed common-anode/cathode seven-segment display, one digit at a time.
- Contains a refresh prescaler, a digit scan counter, a guard (anti-ghosting) slot, leading-zero blanking and invalid-digit detection.
- Sits between the BCD counter's `out[7:0]` and the board's segment/anode pins.

Parameters:
- DIGITS, 2, number of BCD digits scanned; bcd_in width is 4*DIGITS.
- PRESCALE, 1000, clk cycles per digit slot; legal range ≥2.
- SEG_ACTIVE_LOW, 1, 1 = segment lines driven low to light.
- AN_ACTIVE_LOW, 1, 1 = anode/select lines driven low to enable.
- BLANK_LZ, 1, 1 = leading-zero blanking enabled.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- bcd_in  input  4*DIGITS  packed BCD, digit 0 = bits [3:0] (least significant)
- load  input  1  capture bcd_in into the shadow register this cycle
- enable  input  1  scan run/hold
- seg_out  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- an_out  output  DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
- digit_err  output  1  some shadow digit > 9
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
Reset:
- Shadow register = 0, prescaler = 0, scan index = 0.
- an_out all inactive, seg_out all unlit, digit_err = 0, frame_done = 0.
- Reset has priority over load and enable in the same cycle.

Capture:
- When load=1 on an edge, shadow <= bcd_in.
- digit_err <= 1 if any nibble of bcd_in > 9, else 0. digit_err changes only on load or reset.
- load is accepted regardless of enable.

Scan timing:
- When enable=1, the prescaler counts 0..PRESCALE-1 and wraps.
- On the edge where the prescaler = PRESCALE-1, the index advances; DIGITS-1 wraps to 0.
- On that wrap edge, frame_done is registered high for exactly one cycle.
- When enable=0, the prescaler and index hold, frame_done = 0, and the outputs are driven to the all-inactive and all-unlit levels from the next cycle.

Outputs:
- seg_out and an_out are registered: they reflect the prescaler, index and shadow values present before the edge, i.e. one cycle of latency.
- Guard slot: when the pre-edge prescaler = 0, an_out is all inactive and seg_out is unlit.
- Otherwise an_out selects the current index only, and seg_out is the decoded shadow nibble for that index.

Decode (active-high gfedcba, inverted when SEG_ACTIVE_LOW=1):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Nibbles A–F decode to dash 40 (g only).

Leading-zero blanking (BLANK_LZ=1):
- Digit i>0 is unlit when it and every more significant digit are 0.
- Digit 0 is never blanked, so value 0 shows a single "0".
- Its anode is still enabled during its slot, so scan timing stays uniform.

Mid-scan update:
- A load during a slot takes effect on the next registered output; there is no wait for a frame boundary.

Test Plan:
1. Reset, then check polarity (DIGITS=2, PRESCALE=4, both polarities active-low). Hold reset 3 cycles → an_out=2'b11, seg_out=7'h7F, digit_err=0, frame_done=0.
2. Normal scan. load bcd_in=8'h47, enable=1 → repeating 8-cycle pattern:
   - 1 guard cycle with an=11, then 3 cycles an=10 with seg=~7'h07 (digit "7").
   - 1 guard cycle, then 3 cycles an=01 with seg=~7'h66 (digit "4").
   - frame_done pulses once per 8 cycles, aligned to the index 1→0 wrap.
3. Leading-zero blanking. load 8'h05 → digit 1 slot: an=01, seg=7'h7F (blank); digit 0 shows ~7'h6D. load 8'h00 → digit 0 shows ~7'h3F.
4. Invalid digit. load 8'h3C → digit_err=1; digit 0 seg=~7'h40 (dash), digit 1 = "3". load 8'h12 → digit_err=0 the next cycle.
5. Enable hold. Deassert enable mid-slot with prescaler=2 → next cycle an=11, seg unlit, frame_done=0. Reassert after 10 cycles → scan resumes at the same index and prescaler=2, with no extra frame_done.
6. Reset mid-operation. Assert reset together with load=1 (bcd_in=8'h99) in the middle of a slot → shadow=0, index=0, digit_err=0. The first post-reset slot is digit 0 showing "0".
